// File: rtl/yuv_tx_pkg.sv
// Shared types and constants for the YUV frame sender: FSM state encoding,
// ctrl bit positions and the flush pulse length.
package yuv_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StWaitSof,
    StStream,
    StDrain,
    StDone
  } yuv_tx_state_e;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlClear = 1;
  localparam int unsigned CtrlPause = 2;

  localparam int unsigned CLEAR_CYCLES = 4;

  // 4:2:0 chroma is kept only where both column and row are even.
  function automatic logic is_chroma_site(logic col_lsb, logic row_lsb);
    return !col_lsb && !row_lsb;
  endfunction

endpackage

// File: rtl/yuv_frame_sender_if.sv
// Three independent valid/accept byte channels (Y, U, V) leaving the frame sender.
interface yuv_frame_sender_if;

  logic [7:0] y_z, u_z, v_z;
  logic       y_lz, u_lz, v_lz;
  logic       y_vz, u_vz, v_vz;

  modport master (
    output y_z, u_z, v_z,
    output y_lz, u_lz, v_lz,
    input  y_vz, u_vz, v_vz
  );

  modport slave (
    input  y_z, u_z, v_z,
    input  y_lz, u_lz, v_lz,
    output y_vz, u_vz, v_vz
  );

endinterface

// File: rtl/yuv_tx_fifo.sv
// Synchronous byte FIFO with a zero-latency head; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module yuv_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Head forced to zero when empty so the output is defined after reset.
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/yuv_frame_sender.sv
// Camera-to-DMA frame sender: one 4:4:4 frame in, Y plus 4:2:0-decimated U/V out
// on three FIFO-backed channels. Define YUV_TX_DROP_CNT_EN to add the drop_cnt output.
module yuv_frame_sender
  import yuv_tx_pkg::*;
#(
  parameter int unsigned FRAME_W    = 64,
  parameter int unsigned FRAME_H    = 64,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                ctrl,
  output logic                      status,
  input  logic                      pix_valid,
  input  logic                      pix_sof,
  input  logic [7:0]                pix_y,
  input  logic [7:0]                pix_u,
  input  logic [7:0]                pix_v,
  yuv_frame_sender_if.master        ch,
  output logic                      clear_dma_and_fifo,
  output logic                      overflow
`ifdef YUV_TX_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int unsigned ColW = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam int unsigned RowW = (FRAME_H > 2) ? $clog2(FRAME_H) : 1;
  localparam int unsigned ClrW = $clog2(CLEAR_CYCLES);
  localparam logic [ColW-1:0] ColLast = ColW'(FRAME_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(FRAME_H - 1);
  localparam logic [ClrW-1:0] ClrLast = ClrW'(CLEAR_CYCLES - 1);

  yuv_tx_state_e   state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic            status_q, status_d;
  logic            overflow_q, overflow_d;
  logic            clear_q, clear_d;

  logic start_req, clear_req, pause;
  logic unused_ctrl;
  logic y_full, u_full, v_full, y_empty, u_empty, v_empty;
  logic y_pop, u_pop, v_pop;
  logic take_pix, chroma_site, room, drop, last_pix, flush;
  logic push_y, push_c;

  assign start_req   = ctrl[CtrlStart];
  assign clear_req   = ctrl[CtrlClear];
  assign pause       = ctrl[CtrlPause];
  assign unused_ctrl = ctrl[3];

  assign y_pop = ch.y_lz && ch.y_vz;
  assign u_pop = ch.u_lz && ch.u_vz;
  assign v_pop = ch.v_lz && ch.v_vz;

  assign ch.y_lz = !y_empty;
  assign ch.u_lz = !u_empty;
  assign ch.v_lz = !v_empty;

  // A pixel belonging to the frame advances the counters whether it is stored or dropped.
  always_comb begin
    take_pix    = pix_valid && !pause &&
                  ((state_q == StWaitSof && pix_sof) || state_q == StStream);
    chroma_site = is_chroma_site(col_q[0], row_q[0]);
    room        = (!y_full || y_pop) &&
                  (!chroma_site || ((!u_full || u_pop) && (!v_full || v_pop)));
    drop        = take_pix && !room;
    push_y      = take_pix && room && !clear_req;
    push_c      = push_y && chroma_site;
    last_pix    = (col_q == ColLast) && (row_q == RowLast);
    flush       = clear_req || (state_q == StClear);
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    clr_cnt_d  = clr_cnt_q;
    status_d   = status_q;
    overflow_d = overflow_q || drop;
    if (clear_req) begin
      state_d    = StClear;
      col_d      = '0;
      row_d      = '0;
      clr_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (take_pix) begin
        if (col_q == ColLast) begin
          col_d = '0;
          row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            state_d  = StWaitSof;
            status_d = 1'b0;
            col_d    = '0;
            row_d    = '0;
          end
        end
        StClear: begin
          col_d      = '0;
          row_d      = '0;
          overflow_d = 1'b0;
          if (clr_cnt_q == ClrLast) state_d = StIdle;
          else clr_cnt_d = clr_cnt_q + ClrW'(1);
        end
        StWaitSof: if (take_pix) state_d = StStream;
        StStream:  if (take_pix && last_pix) state_d = StDrain;
        StDrain: begin
          if (y_empty && u_empty && v_empty) begin
            state_d  = StDone;
            status_d = 1'b1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    clear_d = (state_d == StClear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      clr_cnt_q  <= '0;
      status_q   <= 1'b0;
      overflow_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      clr_cnt_q  <= clr_cnt_d;
      status_q   <= status_d;
      overflow_q <= overflow_d;
      clear_q    <= clear_d;
    end
  end

  assign status             = status_q;
  assign overflow           = overflow_q;
  assign clear_dma_and_fifo = clear_q;

`ifdef YUV_TX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_req || (state_q == StIdle && start_req)) begin
      drop_cnt_d = '0;
    end else if (drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  yuv_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_y (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push_y),
    .data_i  (pix_y),
    .pop_i   (y_pop),
    .data_o  (ch.y_z),
    .full_o  (y_full),
    .empty_o (y_empty)
  );

  yuv_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_u (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push_c),
    .data_i  (pix_u),
    .pop_i   (u_pop),
    .data_o  (ch.u_z),
    .full_o  (u_full),
    .empty_o (u_empty)
  );

  yuv_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_v (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push_c),
    .data_i  (pix_v),
    .pop_i   (v_pop),
    .data_o  (ch.v_z),
    .full_o  (v_full),
    .empty_o (v_empty)
  );

endmodule

// File: doc/yuv_frame_sender.md
YUV_FRAME_SENDER -- requirements
Module: yuv_frame_sender

Interface
REQ-001 Parameter FRAME_W, default 64: pixels per line; even, 2..4096.
REQ-002 Parameter FRAME_H, default 64: lines per frame; even, 2..4096.
REQ-003 Parameter FIFO_DEPTH, default 16: entries per channel FIFO; power of two, >= 4.
REQ-004 The block SHALL have this port list (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- ctrl  in  4  HPS control: [0] start pulse, [1] clear pulse, [2] pause level, [3] reserved (ignored).
- status  out  1  frame_done, sticky.
- pix_valid  in  1  camera pixel strobe.
- pix_sof  in  1  start of frame; qualified by pix_valid.
- pix_y, pix_u, pix_v  in  8 each  camera pixel, 4:4:4.
- y_z, u_z, v_z  out  8 each  channel data.
- y_lz, u_lz, v_lz  out  1 each  channel data valid.
- y_vz, u_vz, v_vz  in  1 each  consumer accept.
- clear_dma_and_fifo  out  1  downstream flush request.
- overflow  out  1  sticky pixel-drop flag.

Function
REQ-005 A channel transfer SHALL occur on a clk edge where x_lz && x_vz; x_z SHALL be stable while x_lz=1 and x_vz=0.
REQ-006 x_lz SHALL equal "channel FIFO non-empty" (zero-latency head), and x_z SHALL be the FIFO head.
REQ-007 States SHALL be IDLE, CLEAR, WAIT_SOF, STREAM, DRAIN, DONE.
REQ-008 IDLE -> WAIT_SOF on ctrl[0]; ctrl[0] SHALL clear status on that edge.
REQ-009 WAIT_SOF -> STREAM on pix_valid && pix_sof; that pixel is pixel (0,0) and SHALL be accepted.
REQ-010 In STREAM each pix_valid pixel SHALL advance col (wraps at FRAME_W-1, increments row); pix_sof is ignored.
REQ-011 Every accepted pixel SHALL push pix_y to the Y FIFO; pix_u and pix_v SHALL be pushed only when col and row are both even (4:2:0 decimation).
REQ-012 A pixel arriving while any FIFO it targets is full SHALL be dropped entirely: no FIFO is pushed, but counters still advance; overflow SHALL be set.
REQ-013 While ctrl[2]=1, pixels SHALL be ignored and counters SHALL hold; x_lz SHALL remain driven by the FIFOs.
REQ-014 After pixel (FRAME_W-1, FRAME_H-1): STREAM -> DRAIN; DRAIN -> DONE when all three FIFOs are empty; DONE sets status=1 and -> IDLE next cycle.
REQ-015 ctrl[1] in any state SHALL enter CLEAR, which takes priority over ctrl[0] in the same cycle.
REQ-016 CLEAR SHALL flush all FIFOs, zero counters and overflow, assert clear_dma_and_fifo for exactly 4 cycles, then -> IDLE.
REQ-017 A simultaneous push and pop on a full FIFO SHALL succeed and leave the count unchanged; pop on an empty FIFO is impossible by construction.

Reset
REQ-018 On reset: state=IDLE, counters and FIFO pointers=0, all x_lz=0, status=0, overflow=0, clear_dma_and_fifo=0; x_z=0.
REQ-019 Reset mid-frame SHALL discard buffered data; after reset deasserts, no channel transfer SHALL occur until a new start.

Configuration
REQ-020 With YUV_TX_DROP_CNT_EN defined: add output drop_cnt, 16 bits, counting dropped pixels, saturating at 0xFFFF, cleared by reset, CLEAR and start. Without it: the port and the counter are absent, and overflow behaves identically.

Structure
REQ-021 Package yuv_tx_pkg SHALL hold the state enum, the ctrl bit-index constants and CLEAR_CYCLES=4.
REQ-022 Sub-module yuv_tx_fifo (sync FIFO, 8-bit data, parameter DEPTH, full/empty/push/pop/flush) SHALL be instantiated three times.

Verification (FRAME_W=4, FRAME_H=4, FIFO_DEPTH=16 unless noted)
REQ-023 Start, then 16 consecutive pixels with y=0..15 and u=v=y, all vz=1 -> Y stream 0..15, U stream 0,2,8,10, V stream 0,2,8,10; status=1; overflow=0.
REQ-024 Same frame with y_vz toggling 1/0 each cycle -> identical streams; y_z is held while y_lz=1 and y_vz=0.
REQ-025 FIFO_DEPTH=4, all vz=0, 16 pixels -> pixels 4..15 dropped, overflow=1; drop_cnt=12 when the macro is enabled; after vz=1, Y carries 0..3 and DONE is reached.
REQ-026 ctrl[1] pulsed after 6 pixels -> clear_dma_and_fifo high for exactly 4 cycles, FIFOs empty, state IDLE, no further output.
REQ-027 reset asserted mid-STREAM for 1 cycle -> all outputs return to reset values; a fresh start plus a frame produces the correct streams from REQ-023.
